alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle control unit that owns the accumulator and sequences the ALU one instruction at a time. Accepts an instruction word over a valid/ready handshake and decodes it using the `instructions.v` opcode macros. Fetches a register operand from the register file when the opcode needs one, drives the ALU, and commits the result to the accumulator. Sits between the instruction fetch path and the ALU/register file; the ALU is instantiated beside it, not inside it.

Parameters:
ADDR_WIDTH, 4, opcode field width (= ALU operation width)
REG_BIT_CNT, 3, register-select field width
DATA_WIDTH, 8, datapath/accumulator width
COMBINED_DATA, ADDR_WIDTH+REG_BIT_CNT+DATA_WIDTH, instruction word width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word present
instr_ready  out  1  sequencer can accept an instruction
instr  in  COMBINED_DATA  {opcode[MSBs], reg_sel, imm[LSBs]}
rf_rd_en  out  1  register-file read strobe
rf_raddr  out  REG_BIT_CNT  register-file read address
rf_rdata  in  DATA_WIDTH  read data, valid the cycle after rf_rd_en
alu_op  out  ADDR_WIDTH  to ALU operation
alu_in1  out  DATA_WIDTH  to ALU in1_acc (always acc)
alu_in2  out  DATA_WIDTH  to ALU in2_reg (operand register)
alu_result  in  DATA_WIDTH  from ALU data_out (low DATA_WIDTH bits)
acc  out  DATA_WIDTH  accumulator
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after acc commit
illegal  out  1  one-cycle pulse, coincident with done, for an opcode matching no macro
zero  out  1  acc == 0, registered with acc

Behaviour:
- Reset (async, rst_n low): state=IDLE; acc, op_q, opnd_q, rf_raddr = 0; rf_rd_en, done, illegal, busy = 0; zero = 1; instr_ready = 1 once rst_n is high.
- Opcode classes:
  - REG: `XOR`, `OR`, `AND`, `SUB`, `ADDr`, `LDr`.
  - IMM: `ADDi`, `LDi`.
  - UNARY: `NOT`, `RR`, `RL`, `DEC`, `INC`, `NOP`.
  - Anything else: ILLEGAL.
- FSM states: IDLE, READ, EXEC, DONE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid: latch opcode into op_q and go busy.
  - REG: rf_raddr <= reg_sel, rf_rd_en pulses 1 cycle, go to READ.
  - IMM: opnd_q <= imm, go to EXEC.
  - UNARY/ILLEGAL: opnd_q <= 0, go to EXEC.
- READ: opnd_q <= rf_rdata, go to EXEC.
- EXEC:
  - alu_op = op_q, alu_in1 = acc, alu_in2 = opnd_q.
  - At the clock edge: acc <= alu_result; zero updated.
  - ILLEGAL: acc is not written.
  - Go to DONE.
- DONE: done = 1 (illegal = 1 for ILLEGAL), instr_ready = 0, next state IDLE.
- alu_op/alu_in2 are held stable from EXEC entry until the next acceptance; they change only in IDLE.
- Latency, acceptance edge to done-high cycle:
  - IMM/UNARY/ILLEGAL: 2 cycles.
  - REG: 3 cycles.
  - Next acceptance is possible the cycle after done.
- instr is sampled only in IDLE with instr_valid high; instr_valid in other states is ignored (the word is held by the producer).
- Arithmetic wraps modulo 2^DATA_WIDTH (ALU behaviour); no saturation.
- rst_n asserted mid-instruction aborts the instruction: no commit, no done, all state returns to reset values.

Optional Feature:
Macro SEQ_CARRY_EN.
- Defined:
  - Adds output carry (1 bit, reset 0), updated in EXEC.
  - ADDr/ADDi/INC: bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum acc + opnd (INC uses 1).
  - SUB/DEC: borrow, i.e. acc < operand.
  - RL: acc[DATA_WIDTH-1]. RR: acc[0].
  - LDr/LDi/logic ops/NOP: carry <= 0.
  - ILLEGAL: carry unchanged.
  - Computed internally from acc/opnd_q, not from the ALU.
- Undefined: no carry port, no carry logic.

Test Plan:
- Reset, then `LDi` imm=0x05 accepted at cycle 0 -> EXEC cycle 1, acc=0x05 and done=1 at cycle 2, zero=0, busy high cycles 1-2.
- Preload r3=0x10, acc=0x05; `ADDr` reg_sel=3 -> rf_rd_en=1 and rf_raddr=3 at cycle 1, acc=0x15 with done at cycle 3.
- acc=0x00, `DEC` -> acc=0xFF, zero=0; with SEQ_CARRY_EN carry=1. Then `INC` -> acc=0x00, zero=1, carry=1.
- instr_valid held high with back-to-back `INC` words -> instr_ready high only in IDLE; one acceptance every 3 cycles; acc increments exactly once per done.
- Opcode matching no macro, acc=0x2A -> done=1 and illegal=1 at cycle 2, acc stays 0x2A.
- `SUB` r1 in flight, rst_n pulled low during EXEC -> acc=0, busy=0, no done pulse; after release instr_ready=1 and zero=1.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bundle of every signal between the sequencer and its neighbours: the instruction
// handshake, the register-file read port, the ALU operand/result lines and the status outputs.
// Modports: slave = sequencer side (it accepts instructions); master = producer/environment side.
// Optional: when SEQ_CARRY_EN is defined, the bundle also carries the 1-bit carry status.
interface alu_sequencer_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int REG_BIT_CNT = 3,
    parameter int DATA_WIDTH  = 8
);
    localparam int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH;

    logic                     instr_valid;
    logic                     instr_ready;
    logic [COMBINED_DATA-1:0] instr;
    logic                     rf_rd_en;
    logic [REG_BIT_CNT-1:0]   rf_raddr;
    logic [DATA_WIDTH-1:0]    rf_rdata;
    logic [ADDR_WIDTH-1:0]    alu_op;
    logic [DATA_WIDTH-1:0]    alu_in1;
    logic [DATA_WIDTH-1:0]    alu_in2;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    acc;
    logic                     busy;
    logic                     done;
    logic                     illegal;
    logic                     zero;
`ifdef SEQ_CARRY_EN
    logic                     carry;
`endif

    modport slave (
`ifdef SEQ_CARRY_EN
        output carry,
`endif
        input  instr_valid, instr, rf_rdata, alu_result,
        output instr_ready, rf_rd_en, rf_raddr, alu_op, alu_in1, alu_in2,
        output acc, busy, done, illegal, zero
    );

    modport master (
`ifdef SEQ_CARRY_EN
        input  carry,
`endif
        output instr_valid, instr, rf_rdata, alu_result,
        input  instr_ready, rf_rd_en, rf_raddr, alu_op, alu_in1, alu_in2,
        input  acc, busy, done, illegal, zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle accumulator sequencer: decodes one instruction, fetches a register operand
// if needed, drives the external ALU and commits its result to the accumulator.
// Latency accept->done: 2 cycles (IMM/UNARY/ILLEGAL), 3 cycles (REG); instr_ready only in IDLE.
// Ports: clk, rst_n (async active-low), bus (alu_sequencer_if.slave). Optional macro SEQ_CARRY_EN adds carry.
`ifndef NOP
`define NOP  4'h0
`endif
`ifndef ADDr
`define ADDr 4'h1
`endif
`ifndef SUB
`define SUB  4'h2
`endif
`ifndef AND
`define AND  4'h3
`endif
`ifndef OR
`define OR   4'h4
`endif
`ifndef XOR
`define XOR  4'h5
`endif
`ifndef NOT
`define NOT  4'h6
`endif
`ifndef INC
`define INC  4'h7
`endif
`ifndef DEC
`define DEC  4'h8
`endif
`ifndef RL
`define RL   4'h9
`endif
`ifndef RR
`define RR   4'hA
`endif
`ifndef LDr
`define LDr  4'hB
`endif
`ifndef LDi
`define LDi  4'hC
`endif
`ifndef ADDi
`define ADDi 4'hD
`endif

module alu_sequencer #(
    parameter int ADDR_WIDTH  = 4,
    parameter int REG_BIT_CNT = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);
    localparam int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;
    typedef enum logic [1:0] {CLS_REG, CLS_IMM, CLS_UNARY, CLS_ILL} op_cls_t;

    function automatic op_cls_t op_class(input logic [ADDR_WIDTH-1:0] op);
        case (op)
            `XOR, `OR, `AND, `SUB, `ADDr, `LDr: op_class = CLS_REG;
            `ADDi, `LDi:                        op_class = CLS_IMM;
            `NOT, `RR, `RL, `DEC, `INC, `NOP:   op_class = CLS_UNARY;
            default:                            op_class = CLS_ILL;
        endcase
    endfunction

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  op_q;
    logic [DATA_WIDTH-1:0]  opnd_q;
    logic [DATA_WIDTH-1:0]  acc_q;
    logic [REG_BIT_CNT-1:0] raddr_q;
    logic                   rd_en_q;
    logic                   done_q;
    logic                   illegal_q;
    logic                   zero_q;

    // Instruction word fields: {opcode, reg_sel, imm}
    logic [ADDR_WIDTH-1:0]  in_op;
    logic [REG_BIT_CNT-1:0] in_reg;
    logic [DATA_WIDTH-1:0]  in_imm;
    assign in_op  = bus.instr[COMBINED_DATA-1 -: ADDR_WIDTH];
    assign in_reg = bus.instr[DATA_WIDTH +: REG_BIT_CNT];
    assign in_imm = bus.instr[DATA_WIDTH-1:0];

    op_cls_t cur_cls;
    assign cur_cls = op_class(op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            raddr_q   <= '0;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        op_q <= in_op;
                        case (op_class(in_op))
                            CLS_REG: begin
                                raddr_q <= in_reg;
                                rd_en_q <= 1'b1;
                                state   <= READ;
                            end
                            CLS_IMM: begin
                                opnd_q <= in_imm;
                                state  <= EXEC;
                            end
                            default: begin
                                opnd_q <= '0;
                                state  <= EXEC;
                            end
                        endcase
                    end
                end
                READ: begin
                    opnd_q <= bus.rf_rdata;
                    state  <= EXEC;
                end
                EXEC: begin
                    // Illegal opcodes still complete (with the illegal flag) but never commit.
                    if (cur_cls != CLS_ILL) begin
                        acc_q  <= bus.alu_result;
                        zero_q <= (bus.alu_result == '0);
                    end
                    done_q    <= 1'b1;
                    illegal_q <= (cur_cls == CLS_ILL);
                    state     <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_CARRY_EN
    // Carry is derived from the sequencer's own operands, independent of the ALU.
    logic                carry_q;
    logic                carry_nxt;
    logic [DATA_WIDTH:0] add_sum;

    always_comb begin
        add_sum   = {1'b0, acc_q} + {1'b0, opnd_q};
        carry_nxt = 1'b0;
        case (op_q)
            `ADDr, `ADDi: carry_nxt = add_sum[DATA_WIDTH];
            `INC:         carry_nxt = &acc_q;
            `SUB:         carry_nxt = (acc_q < opnd_q);
            `DEC:         carry_nxt = (acc_q == '0);
            `RL:          carry_nxt = acc_q[DATA_WIDTH-1];
            `RR:          carry_nxt = acc_q[0];
            default:      carry_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (state == EXEC && cur_cls != CLS_ILL) begin
            carry_q <= carry_nxt;
        end
    end

    assign bus.carry = carry_q;
`endif

    // Ready only out of reset and in IDLE; the producer holds the word otherwise.
    assign bus.instr_ready = rst_n && (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.rf_rd_en    = rd_en_q;
    assign bus.rf_raddr    = raddr_q;
    assign bus.alu_op      = op_q;
    assign bus.alu_in1     = acc_q;
    assign bus.alu_in2     = opnd_q;
    assign bus.acc         = acc_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.zero        = zero_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: models the neighbouring ALU and register file,
// drives directed and random instructions, and compares against an arithmetic reference model.
// Carry checks are compiled in only when SEQ_CARRY_EN is defined.
`ifndef NOP
`define NOP  4'h0
`endif
`ifndef ADDr
`define ADDr 4'h1
`endif
`ifndef SUB
`define SUB  4'h2
`endif
`ifndef AND
`define AND  4'h3
`endif
`ifndef OR
`define OR   4'h4
`endif
`ifndef XOR
`define XOR  4'h5
`endif
`ifndef NOT
`define NOT  4'h6
`endif
`ifndef INC
`define INC  4'h7
`endif
`ifndef DEC
`define DEC  4'h8
`endif
`ifndef RL
`define RL   4'h9
`endif
`ifndef RR
`define RR   4'hA
`endif
`ifndef LDr
`define LDr  4'hB
`endif
`ifndef LDi
`define LDi  4'hC
`endif
`ifndef ADDi
`define ADDi 4'hD
`endif

module tb_alu_sequencer;
    localparam int AW = 4;
    localparam int RW = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if #(.ADDR_WIDTH(AW), .REG_BIT_CNT(RW), .DATA_WIDTH(DW)) bus ();

    alu_sequencer #(.ADDR_WIDTH(AW), .REG_BIT_CNT(RW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Neighbouring register file (asynchronous read of the registered address).
    logic [7:0] rf [8];
    assign bus.rf_rdata = rf[bus.rf_raddr];

    // Neighbouring ALU; undefined opcodes produce a scrambled value so a wrong commit shows up.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            `NOP:         alu_f = a;
            `ADDr, `ADDi: alu_f = a + b;
            `SUB:         alu_f = a - b;
            `AND:         alu_f = a & b;
            `OR:          alu_f = a | b;
            `XOR:         alu_f = a ^ b;
            `NOT:         alu_f = ~a;
            `INC:         alu_f = a + 8'd1;
            `DEC:         alu_f = a - 8'd1;
            `RL:          alu_f = {a[6:0], a[7]};
            `RR:          alu_f = {a[0], a[7:1]};
            `LDr, `LDi:   alu_f = b;
            default:      alu_f = a ^ 8'h5A;
        endcase
    endfunction
    assign bus.alu_result = alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] m_acc   = 8'h00;
    logic       m_carry = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // 0 = register operand, 1 = immediate, 2 = unary, 3 = illegal
    function automatic int op_cls(input logic [3:0] op);
        case (op)
            `XOR, `OR, `AND, `SUB, `ADDr, `LDr: op_cls = 0;
            `ADDi, `LDi:                        op_cls = 1;
            `NOT, `RR, `RL, `DEC, `INC, `NOP:   op_cls = 2;
            default:                            op_cls = 3;
        endcase
    endfunction

    // Reference model in plain integer arithmetic: returns {carry, acc}.
    function automatic logic [8:0] ref_step(input logic [3:0] op, input logic [7:0] acc,
                                            input logic [7:0] opnd, input logic cin);
        int a, o, r, c;
        a = int'(acc);
        o = int'(opnd);
        r = a;
        c = 0;
        case (op)
            `ADDr, `ADDi: begin r = (a + o) % 256; c = (a + o > 255) ? 1 : 0; end
            `SUB:         begin r = (a - o + 256) % 256; c = (a < o) ? 1 : 0; end
            `INC:         begin r = (a + 1) % 256; c = (a == 255) ? 1 : 0; end
            `DEC:         begin r = (a + 255) % 256; c = (a == 0) ? 1 : 0; end
            `AND:         r = a & o;
            `OR:          r = a | o;
            `XOR:         r = a ^ o;
            `NOT:         r = 255 - a;
            `RL:          begin r = (a * 2) % 256 + a / 128; c = a / 128; end
            `RR:          begin r = a / 2 + (a % 2) * 128; c = a % 2; end
            `LDr, `LDi:   r = o;
            `NOP:         r = a;
            default:      begin r = a; c = int'(cin); end
        endcase
        ref_step = {c[0], r[7:0]};
    endfunction

    // Called #1 after a clock edge with the DUT idle; returns #1 after the edge following done.
    task automatic do_instr(input logic [3:0] op, input logic [2:0] rs, input logic [7:0] imm);
        logic [7:0] opnd;
        logic [7:0] a0;
        logic [8:0] nx;
        int cls, exp_lat, cyc;
        bit got;
        cls     = op_cls(op);
        opnd    = (cls == 0) ? rf[rs] : (cls == 1) ? imm : 8'h00;
        a0      = m_acc;
        nx      = ref_step(op, m_acc, opnd, m_carry);
        exp_lat = (cls == 0) ? 3 : 2;
        chk("ready_idle", 32'(bus.instr_ready), 32'd1);
        bus.instr       = {op, rs, imm};
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 15'($urandom);
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 6) begin
            chk("busy", 32'(bus.busy), 32'd1);
            if (cyc == 1) begin
                chk("rf_rd_en", 32'(bus.rf_rd_en), 32'(cls == 0));
                if (cls == 0) chk("rf_raddr", 32'(bus.rf_raddr), 32'(rs));
            end
            if (cyc == exp_lat - 1) begin
                chk("alu_op", 32'(bus.alu_op), 32'(op));
                chk("alu_in1", 32'(bus.alu_in1), 32'(a0));
                chk("alu_in2", 32'(bus.alu_in2), 32'(opnd));
            end
            if (bus.done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        m_acc   = nx[7:0];
        m_carry = nx[8];
        chk("acc", 32'(bus.acc), 32'(m_acc));
        chk("zero", 32'(bus.zero), 32'(m_acc == 8'h00));
        chk("illegal", 32'(bus.illegal), 32'(cls == 3));
`ifdef SEQ_CARRY_EN
        chk("carry", 32'(bus.carry), 32'(m_carry));
`endif
        @(posedge clk); #1;
        chk("done_clear", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int dones;
        logic [8:0] nx;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        for (int i = 0; i < 8; i++) rf[i] = 8'(i * 17);

        // Reset values
        #12;
        chk("rst_acc", 32'(bus.acc), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_rd_en", 32'(bus.rf_rd_en), 32'd0);
        chk("rst_raddr", 32'(bus.rf_raddr), 32'd0);
        chk("rst_alu_in2", 32'(bus.alu_in2), 32'd0);
`ifdef SEQ_CARRY_EN
        chk("rst_carry", 32'(bus.carry), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);

        // Directed cases
        do_instr(`LDi, 3'd0, 8'h05);
        rf[3] = 8'h10;
        do_instr(`ADDr, 3'd3, 8'h00);
        do_instr(`LDi, 3'd0, 8'h00);
        do_instr(`DEC, 3'd0, 8'h00);
        do_instr(`INC, 3'd0, 8'h00);
        do_instr(`LDi, 3'd0, 8'h2A);
        do_instr(4'hE, 3'd2, 8'h77);
        do_instr(4'hF, 3'd5, 8'h01);

        // Back-to-back INC with instr_valid held, wrapping through zero
        do_instr(`LDi, 3'd0, 8'hFB);
        bus.instr       = {`INC, 3'd0, 8'h00};
        bus.instr_valid = 1'b1;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            chk("b2b_ready", 32'(bus.instr_ready), 32'(k % 3 == 0));
            chk("b2b_done", 32'(bus.done), 32'(k % 3 == 2));
            if (bus.done) begin
                dones++;
                nx      = ref_step(`INC, m_acc, 8'h00, m_carry);
                m_acc   = nx[7:0];
                m_carry = nx[8];
                chk("b2b_acc", 32'(bus.acc), 32'(m_acc));
                chk("b2b_zero", 32'(bus.zero), 32'(m_acc == 8'h00));
            end
            if (k == 29) bus.instr_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("b2b_count", 32'(dones), 32'd10);
        chk("b2b_idle", 32'(bus.busy), 32'd0);

        // Random instructions, including illegal opcodes and register-file churn
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) rf[$urandom_range(0, 7)] = 8'($urandom);
            do_instr(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 8'($urandom));
        end

        // Reset asserted during EXEC of a register SUB aborts it
        do_instr(`LDi, 3'd0, 8'h40);
        rf[1] = 8'h11;
        bus.instr       = {`SUB, 3'd1, 8'h00};
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_exec", 32'(bus.alu_op), 32'(`SUB));
        rst_n = 1'b0;
        #1;
        chk("abort_acc", 32'(bus.acc), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        chk("abort_no_done", 32'(bus.done), 32'd0);
        chk("abort_acc_held", 32'(bus.acc), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", 32'(bus.instr_ready), 32'd1);
        chk("abort_zero", 32'(bus.zero), 32'd1);
        chk("abort_idle", 32'(bus.busy), 32'd0);
`ifdef SEQ_CARRY_EN
        chk("abort_carry", 32'(bus.carry), 32'd0);
`endif
        m_acc   = 8'h00;
        m_carry = 1'b0;
        do_instr(`ADDi, 3'd0, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Independent watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
